apb_reg_slave: RTL and testbench

APB3 completer (slave) that terminates the APB master port of the AHB-to-APB bridge and exposes a small bank of 32-bit control/status registers to the rest of the design. It decodes word-aligned addresses and inserts a configurable number of wait states through PREADY. It flags bad accesses on PSLVERR and presents register contents and per-register write strobes to downstream logic.

---
 rtl/apb_reg_pkg.sv | 20 ++
 rtl/apb_reg_bank.sv | 62 ++++++
 rtl/apb_reg_slave.sv | 132 +++++++++++++
 tb/tb_apb_reg_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_pkg.sv
// Shared constants and types for the APB register slave and its register bank.
package apb_reg_pkg;

    localparam int APB_DW   = 32;
    localparam int ADDR_LSB = 2;

    localparam logic [APB_DW-1:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    // Register index width; never below one bit so port widths stay legal.
    function automatic int idx_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the APB slave: read-only ID at index 0, writable
// registers above it, a combinational read mux and one-cycle write strobes.
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int                NREGS    = 8,
    parameter logic [APB_DW-1:0] ID_VALUE = ID_VALUE_DEFAULT,
    localparam int               IDX_W    = idx_width(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [APB_DW-1:0]       wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [APB_DW-1:0]       rd_data,
    output logic [NREGS*APB_DW-1:0] regs_q,
    output logic [NREGS-1:0]        wr_pulse
);

    localparam int TBL_N = 1 << IDX_W;

    logic [APB_DW-1:0] mem [1:NREGS-1];
    logic [APB_DW-1:0] rd_tbl [TBL_N];

    // NOTE: the register file is small control state that downstream logic
    // observes directly, so every entry is reset rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    mem[i]      <= wr_data;
                    wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    // Table padded to a power of two so any index value selects something.
    for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
        if (g == 0) begin : g_id
            assign rd_tbl[g] = ID_VALUE;
        end else if (g < NREGS) begin : g_reg
            assign rd_tbl[g] = mem[g];
        end else begin : g_pad
            assign rd_tbl[g] = '0;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_q[g*APB_DW +: APB_DW] = rd_tbl[g];
    end

    assign rd_data = rd_tbl[rd_idx];

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer: address decode, wait-state FSM and registered response,
// fronting the apb_reg_bank register array.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int                NREGS       = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [APB_DW-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [APB_DW-1:0]       paddr,
    input  logic [APB_DW-1:0]       pwdata,
    output logic [APB_DW-1:0]       prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [NREGS*APB_DW-1:0] regs_q,
    output logic [NREGS-1:0]        wr_pulse
);

    localparam int          IDX_W    = idx_width(NREGS);
    localparam int          WORD_W   = APB_DW - ADDR_LSB;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic              lat_write;
    logic              lat_err;

    logic [WORD_W-1:0] dec_word;
    logic [IDX_W-1:0]  dec_idx;
    logic              dec_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [APB_DW-1:0] rd_data;
    logic              wr_en;

    assign dec_word = paddr[APB_DW-1:ADDR_LSB];
    assign dec_idx  = paddr[ADDR_LSB +: IDX_W];
    assign dec_err  = (paddr[ADDR_LSB-1:0] != '0)
                    || (dec_word >= WORD_W'(NREGS))
                    || (pwrite && dec_word == '0);

    // In IDLE the zero-wait path loads read data straight from the live decode.
    assign rd_idx = (state == ST_IDLE) ? dec_idx : lat_idx;
    assign wr_en  = (state == ST_DONE) && psel && penable && lat_write && !lat_err;

    // NOTE: all state below updates with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        lat_idx   <= dec_idx;
                        lat_write <= pwrite;
                        lat_err   <= dec_err;
                        if (WAIT_CYCLES == 0) begin
                            state   <= ST_DONE;
                            pready  <= 1'b1;
                            pslverr <= dec_err;
                            prdata  <= (!pwrite && !dec_err) ? rd_data : '0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        state   <= ST_DONE;
                        pready  <= 1'b1;
                        pslverr <= lat_err;
                        prdata  <= (!lat_write && !lat_err) ? rd_data : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Completion and abort both clear the response; only
                    // completion commits a write, via wr_en into the bank.
                    if (!psel || penable) begin
                        state   <= ST_IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
            endcase
        end
    end

    apb_reg_bank #(
        .NREGS    (NREGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (lat_idx),
        .wr_data  (pwdata),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: three instances (0, 1 and 15 wait states)
// on a shared APB bus, one selected per transfer, checked by a negedge monitor.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    typedef struct {
        int          inst;
        logic        wr;
        logic        err;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        psel_v = '0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [31:0]       paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [2:0][31:0]  prdata_v;
    logic [2:0]        pready_v;
    logic [2:0]        pslverr_v;
    logic [2:0][255:0] regs_v;
    logic [2:0][7:0]   pulse_v;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];

    logic [31:0] model  [3][8];
    logic [31:0] shadow [3][8];
    logic        pend_v [3];
    logic [2:0]  pend_idx [3];
    logic [31:0] pend_data [3];
    logic [7:0]  exp_pulse [3];
    int          acc [3];
    logic        rst_seen = 1'b0;

    always #5 clk = ~clk;

    apb_reg_slave #(.NREGS(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]), .regs_q(regs_v[0]), .wr_pulse(pulse_v[0]));

    apb_reg_slave #(.NREGS(8), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]), .regs_q(regs_v[1]), .wr_pulse(pulse_v[1]));

    apb_reg_slave #(.NREGS(8), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]), .regs_q(regs_v[2]), .wr_pulse(pulse_v[2]));

    function automatic int wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle register/strobe tracking plus response scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [255:0] ef;
                exp_t e;
                if (rst_seen) begin
                    for (int i = 0; i < 8; i++) shadow[k][i] = '0;
                    pend_v[k]    = 1'b0;
                    exp_pulse[k] = '0;
                    acc[k]       = 0;
                end else if (pend_v[k]) begin
                    shadow[k][pend_idx[k]] = pend_data[k];
                    exp_pulse[k] = 8'(1) << pend_idx[k];
                    pend_v[k]    = 1'b0;
                end else begin
                    exp_pulse[k] = '0;
                end
                ef = '0;
                for (int i = 0; i < 8; i++) ef[32*i +: 32] = (i == 0) ? ID : shadow[k][i];
                check($sformatf("regs_q[%0d]", k), regs_v[k], ef);
                check($sformatf("wr_pulse[%0d]", k), 256'(pulse_v[k]), 256'(exp_pulse[k]));

                if (pready_v[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_pready[%0d]", k), 256'(pready_v[k]), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_inst", 256'(k), 256'(e.inst));
                        check($sformatf("prdata[%0d]", k), 256'(prdata_v[k]), 256'(e.rdata));
                        check($sformatf("pslverr[%0d]", k), 256'(pslverr_v[k]), 256'(e.err));
                        check($sformatf("latency[%0d]", k), 256'(acc[k] + 1), 256'(wait_of(k) + 1));
                        if (psel_v[k] && penable && !rst && e.wr && !e.err) begin
                            pend_v[k]    = 1'b1;
                            pend_idx[k]  = e.idx;
                            pend_data[k] = e.wdata;
                        end
                    end
                    acc[k] = 0;
                end else begin
                    check($sformatf("idle_prdata[%0d]", k), 256'(prdata_v[k]), 256'(0));
                    check($sformatf("idle_pslverr[%0d]", k), 256'(pslverr_v[k]), 256'(0));
                    if (psel_v[k] && penable) acc[k]++;
                    else acc[k] = 0;
                end
            end
            rst_seen = rst;
        end
    end

    // mode 0: normal, 1: abort by dropping psel after setup, 2: reset in DONE.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int mode);
        exp_t e;
        int   word;
        int   n;
        bit   timed_out;
        word    = int'(addr >> 2);
        e.inst  = k;
        e.wr    = wr;
        e.err   = (addr[1:0] != 2'b00) || (word >= 8) || (wr && word == 0);
        e.idx   = addr[4:2];
        e.wdata = data;
        e.rdata = (wr || e.err) ? 32'h0 : ((word == 0) ? ID : model[k][word]);
        if (mode != 1) exp_q.push_back(e);
        if (mode == 0 && wr && !e.err) model[k][word] = data;

        psel_v    = '0;
        psel_v[k] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = data;
        @(posedge clk); #1;
        if (mode == 1) begin
            psel_v  = '0;
            @(posedge clk); #1;
            return;
        end
        penable = 1'b1;
        if (mode == 2) begin
            repeat (wait_of(k)) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst     = 1'b0;
            psel_v  = '0;
            penable = 1'b0;
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 8; i++) model[j][i] = '0;
            return;
        end
        n = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (pready_v[k]) break;
            if (n >= 40) begin timed_out = 1'b1; break; end
            @(posedge clk); #1;
            n++;
        end
        check("xfer_timeout", 256'(timed_out), 256'(0));
        @(posedge clk); #1;
        psel_v  = '0;
        penable = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        int          r;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 8; i++) begin
                model[j][i]  = '0;
                shadow[j][i] = '0;
            end
            pend_v[j]    = 1'b0;
            pend_idx[j]  = '0;
            pend_data[j] = '0;
            exp_pulse[j] = '0;
            acc[j]       = 0;
        end
        @(posedge clk); @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        xfer(1, 1'b0, 32'h0, 32'h0, 0);
        xfer(1, 1'b1, 32'h4, 32'hDEAD_BEEF, 0);
        xfer(1, 1'b0, 32'h4, 32'h0, 0);
        xfer(1, 1'b1, 32'h0, 32'h1111_1111, 0);
        xfer(1, 1'b1, 32'h6, 32'h2222_2222, 0);
        xfer(1, 1'b1, 32'h20, 32'h3333_3333, 0);
        xfer(1, 1'b0, 32'h24, 32'h0, 0);
        xfer(1, 1'b0, 32'h4, 32'h0, 0);
        idle(1);

        xfer(0, 1'b1, 32'h8, 32'h0BAD_F00D, 0);
        xfer(0, 1'b0, 32'h8, 32'h0, 0);
        xfer(2, 1'b1, 32'h8, 32'h1234_5678, 0);
        xfer(2, 1'b0, 32'h8, 32'h0, 0);
        idle(1);

        xfer(1, 1'b1, 32'hC, 32'hCAFE_0003, 1);
        idle(2);
        xfer(1, 1'b0, 32'hC, 32'h0, 0);

        xfer(1, 1'b1, 32'h10, 32'h4444_4444, 2);
        idle(2);
        xfer(1, 1'b0, 32'h10, 32'h0, 0);
        xfer(1, 1'b0, 32'h4, 32'h0, 0);

        for (int t = 0; t < 80; t++) begin
            k = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 7)) << 2;
            if (r == 6) a = a | 32'($urandom_range(1, 3));
            else if (r == 7) a = 32'h20 + (32'($urandom_range(0, 7)) << 2);
            else if (r == 8) a = 32'h8000_0000 | a;
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(3);
        check("queue_empty", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
